// File: rtl/my_uart_rx.sv
// UART receiver: 2-flop synchronized line, majority-of-3 mid-bit sampling, overrun/framing flags.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
module my_uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_parity_err
);

    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;
`endif

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_s0;
    logic          r_s1;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_overrun;

    logic w_rx;
    logic w_maj;
    logic w_at_dec;
    logic w_at_end;
    logic w_tick_clr;
    logic w_tick_inc;
    logic w_bit_clr;
    logic w_bit_inc;
    logic w_shift_en;
    logic w_good;
    logic w_frame_err;
    logic w_parity_err;

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic w_par_en;
`endif

    assign w_rx     = r_sync2;
    assign w_maj    = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_at_dec = (r_tick == T_DEC);
    assign w_at_end = (r_tick == T_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tick_clr   = 1'b0;
        w_tick_inc   = 1'b0;
        w_bit_clr    = 1'b0;
        w_bit_inc    = 1'b0;
        w_shift_en   = 1'b0;
        w_good       = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en     = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = S_START;
                    w_tick_clr  = 1'b1;
                end
            end
            S_START: begin
                if (w_at_dec && w_maj) begin
                    w_state_nxt = S_IDLE;
                    w_tick_clr  = 1'b1;
                end else if (w_at_end) begin
                    w_state_nxt = S_DATA;
                    w_tick_clr  = 1'b1;
                    w_bit_clr   = 1'b1;
                end else begin
                    w_tick_inc = 1'b1;
                end
            end
            S_DATA: begin
                w_shift_en = w_at_dec;
                if (w_at_end) begin
                    w_tick_clr = 1'b1;
                    if (r_bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end else begin
                    w_tick_inc = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_par_en = w_at_dec;
                if (w_at_end) begin
                    w_state_nxt = S_STOP;
                    w_tick_clr  = 1'b1;
                end else begin
                    w_tick_inc = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_at_dec) begin
                    w_tick_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    w_parity_err = ^{r_shift, r_par};
`endif
                    if (w_maj) begin
                        w_state_nxt = S_IDLE;
                        w_good      = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_IDLE;
                        w_frame_err = 1'b1;
                    end
                end else begin
                    w_tick_inc = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                // Line must stay high a full bit period before re-arming.
                if (!w_rx) begin
                    w_tick_clr = 1'b1;
                end else if (w_at_end) begin
                    w_state_nxt = S_IDLE;
                    w_tick_clr  = 1'b1;
                end else begin
                    w_tick_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick   <= '0;
            r_bitcnt <= 3'd0;
        end else begin
            if (w_tick_clr) begin
                r_tick <= '0;
            end else if (w_tick_inc) begin
                r_tick <= r_tick + 1'b1;
            end
            if (w_bit_clr) begin
                r_bitcnt <= 3'd0;
            end else if (w_bit_inc) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
            r_shift <= 8'h00;
        end else begin
            if (r_tick == T_S0) begin
                r_s0 <= w_rx;
            end
            if (r_tick == T_S1) begin
                r_s1 <= w_rx;
            end
            if (w_shift_en) begin
                r_shift[r_bitcnt] <= w_maj;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_par_en) begin
            r_par <= w_maj;
        end
    end
`endif

    // A load coinciding with an ack wins; otherwise a held byte blocks the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_good) begin
            if (r_valid && !rx_ack) begin
                r_overrun <= 1'b1;
            end else begin
                r_data    <= r_shift;
                r_valid   <= 1'b1;
                r_overrun <= 1'b0;
            end
        end else if (rx_ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_overrun    = r_overrun;
    assign rx_busy       = (r_state != S_IDLE);
    assign rx_frame_err  = w_frame_err;
    assign rx_parity_err = w_parity_err;

endmodule

// File: tb/tb_my_uart_rx.sv
// Directed self-checking bench for my_uart_rx at 16x oversampling.
// Parity case is exercised when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_my_uart_rx;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // sync(2) + idle detect(1) + bits before stop + stop decision tick + load(1)
    localparam int LAT = 2 + 1 + (NB - 1) * OS + (OS / 2 + 1) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_parity_err;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    int fe_run  = 0;
    int fe_max  = 0;
    int pe_cnt  = 0;
    int busy_seen = 0;
    int lat;

    my_uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_parity_err(rx_parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_frame_err) begin
            fe_cnt++;
            fe_run++;
            if (fe_run > fe_max) fe_max = fe_run;
        end else begin
            fe_run = 0;
        end
        if (rx_parity_err) pe_cnt++;
        if (rx_busy) busy_seen = 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop,
                        input logic pflip);
        uart_rx = 1'b0;
        idle(OS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            idle(OS);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^d) ^ pflip;
        idle(OS);
`endif
        uart_rx = stop;
        idle(OS);
        uart_rx = 1'b1;
    endtask

    task automatic send_timed(input logic [7:0] d, input logic pflip,
                              output int cyc);
        int c;
        c = 0;
        fork
            send(d, 1'b1, pflip);
            begin
                do begin
                    @(negedge clk);
                    c++;
                end while (!rx_valid && c < 400);
            end
        join
        cyc = c;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        rx_ack  = 1'b0;
        idle(3);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_ovr", rx_overrun, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_perr", rx_parity_err, 0);
        rst = 1'b0;
        idle(5);

        // Clean 0xA5
        send_timed(8'hA5, 1'b0, lat);
        check("a5_latency", lat, LAT);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_valid, 1);
        check("a5_ovr", rx_overrun, 0);
        check("a5_ferr", fe_cnt, 0);
        check("a5_perr", pe_cnt, 0);
        ack_pulse();
        check("a5_ack_valid", rx_valid, 0);
        check("a5_ack_data", rx_data, 8'hA5);

        // 4-cycle glitch on idle line
        idle(10);
        busy_seen = 0;
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(40);
        check("gl_busy_seen", busy_seen, 1);
        check("gl_busy_end", rx_busy, 0);
        check("gl_valid", rx_valid, 0);
        check("gl_ferr", fe_cnt, 0);

        // Back-to-back 0x3C, 0xC3 without ack
        send(8'h3C, 1'b1, 1'b0);
        send(8'hC3, 1'b1, 1'b0);
        idle(4);
        check("b2b_data", rx_data, 8'h3C);
        check("b2b_valid", rx_valid, 1);
        check("b2b_ovr", rx_overrun, 1);

        // Ack in the same cycle as a new load
        fork
            send(8'h96, 1'b1, 1'b0);
            begin
                idle(LAT - 1);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                check("ackld_data", rx_data, 8'h96);
                check("ackld_valid", rx_valid, 1);
                check("ackld_ovr", rx_overrun, 0);
            end
        join
        ack_pulse();
        check("clr_valid", rx_valid, 0);
        check("clr_ovr", rx_overrun, 0);
        check("clr_data", rx_data, 8'h96);

        // Framing error then recovery
        idle(5);
        fe_cnt = 0;
        fe_max = 0;
        send(8'h55, 1'b0, 1'b0);
        idle(40);
        check("fe_count", fe_cnt, 1);
        check("fe_width", fe_max, 1);
        check("fe_valid", rx_valid, 0);
        check("fe_data", rx_data, 8'h96);
        check("fe_busy", rx_busy, 0);
        send_timed(8'h12, 1'b0, lat);
        check("fe_next_lat", lat, LAT);
        check("fe_next_data", rx_data, 8'h12);
        check("fe_next_ferr", fe_cnt, 1);

        // Reset during data bit 4
        idle(5);
        fork
            send(8'hFF, 1'b1, 1'b0);
            begin
                idle(OS * 5 + 8);
                rst = 1'b1;
                idle(2);
                check("mid_rst_busy", rx_busy, 0);
                rst = 1'b0;
                @(negedge clk);
                check("mid_rst_data", rx_data, 8'h00);
                check("mid_rst_valid", rx_valid, 0);
                check("mid_rst_ovr", rx_overrun, 0);
            end
        join
        idle(10);
        check("post_rst_idle", rx_valid, 0);
        send_timed(8'hFF, 1'b0, lat);
        check("ff_lat", lat, LAT);
        check("ff_data", rx_data, 8'hFF);
        check("ff_ferr", fe_cnt, 1);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        idle(5);
        pe_cnt = 0;
        send_timed(8'h07, 1'b1, lat);
        check("par_lat", lat, LAT);
        check("par_err", pe_cnt, 1);
        check("par_data", rx_data, 8'h07);
        check("par_valid", rx_valid, 1);
`else
        check("par_tied0", pe_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/my_uart_rx.md
MY_UART_RX -- requirements
Module: my_uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, clk cycles per bit period; even, at least 8.
REQ-002 clk  input  1  oversample clock, exactly OVERSAMPLE cycles per bit; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 uart_rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 rx_ack  input  1  consumer acknowledge; a high level clears rx_valid and rx_overrun.
REQ-006 rx_data  output  8  last received byte, LSB first on the line.
REQ-007 rx_valid  output  1  byte available; held high until acknowledged.
REQ-008 rx_busy  output  1  high in every state except IDLE.
REQ-009 rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 rx_overrun  output  1  sticky flag: a frame completed while rx_valid was high.
REQ-011 rx_parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic uses the synchronized value.
REQ-013 States: IDLE, START, DATA, PARITY (only when parity is compiled in), STOP, WAIT_IDLE.
REQ-014 Tick counter: 0..OVERSAMPLE-1, cleared on every state entry; bit counter: 0..7.
REQ-015 IDLE -> START on the first synchronized low; tick counter cleared.
REQ-016 Bit value SHALL be the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-017 START: decide at tick OVERSAMPLE/2+1; majority 1 -> IDLE (false start, no flags); else continue to the end of the bit, then -> DATA.
REQ-018 DATA: shift the majority value into bit[count] at tick OVERSAMPLE/2+1; after bit 7 completes its period -> PARITY, or -> STOP when parity is compiled out.
REQ-019 STOP: decide at tick OVERSAMPLE/2+1 without waiting for the full stop period; majority 1 -> frame good, -> IDLE; majority 0 -> WAIT_IDLE.
REQ-020 Good frame: on the cycle after the stop decision, load rx_data and set rx_valid; latency is 1 cycle from the decision to rx_valid=1.
REQ-021 Frame completing while rx_valid=1 and rx_ack=0: rx_data unchanged, rx_overrun set, new byte discarded.
REQ-022 rx_ack=1 on the same cycle a good frame loads: new byte loaded, rx_valid stays 1, rx_overrun cleared, not set.
REQ-023 rx_ack=1 with no new frame: rx_valid and rx_overrun go 0 next cycle; rx_data holds.
REQ-024 Framing error: pulse rx_frame_err, discard byte, leave rx_valid/rx_data untouched; WAIT_IDLE -> IDLE only after OVERSAMPLE consecutive high samples (break tolerance).
REQ-025 Frames SHALL be receivable back-to-back with a single stop bit.

Reset
REQ-026 On rst: state IDLE, counters 0, synchronizer 1, rx_data 8'h00, rx_valid/rx_busy/rx_frame_err/rx_overrun/rx_parity_err 0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no flags; reception resumes with the next falling edge after rst deasserts.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: one even-parity bit follows bit 7 and is sampled like a data bit; a mismatch pulses rx_parity_err in the stop-decision cycle, and the byte is still delivered.
REQ-029 UART_RX_PARITY_EN undefined: no PARITY state; frame = start + 8 data + stop; rx_parity_err tied 0.

Verification
REQ-030 Byte 8'hA5, 16x, clean line -> rx_valid rises 1 cycle after the stop mid-sample, rx_data=8'hA5, no error flags.
REQ-031 Low glitch of 4 cycles on an idle line -> returns to IDLE, rx_busy pulses, no rx_valid, no error flags.
REQ-032 Frames 8'h3C then 8'hC3 back-to-back, no rx_ack -> rx_data=8'h3C, rx_overrun=1; rx_ack -> both clear.
REQ-033 8'h55 with stop bit forced low, line high 16 cycles later -> rx_frame_err single pulse, rx_valid stays 0, next frame 8'h12 received OK.
REQ-034 rst pulsed during data bit 4, then 8'hFF sent -> all outputs at reset values, then rx_data=8'hFF.
REQ-035 UART_RX_PARITY_EN defined, 8'h07 sent with parity bit 0 -> rx_parity_err pulse, rx_data=8'h07, rx_valid=1.
